ks_add_stream: RTL and testbench

Streaming valid/ready front-end for the 16-bit Kogge-Stone adder. It registers operand pairs and drives them onto the combinational adder, then captures the sum with carry/overflow flags into a 2-entry output buffer. It also keeps a running accumulator, so the adder can serve both one-shot additions and accumulation streams without stalling the producer.

---
 rtl/ks_add_stream_pkg.sv | 34 +++
 rtl/ks_add_stream_if.sv | 29 ++
 rtl/ks_add_stream_fifo.sv | 42 ++++
 rtl/ks_add_stream.sv | 102 ++++++++++
 tb/tb_ks_add_stream.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ks_add_stream_pkg.sv
// Shared types for the ks_add_stream front-end: op codes, S1 beat and result entry.
// KS_ADD_SAT_EN (see ks_add_stream.sv) selects saturating ACC.
package ks_add_pkg;
   localparam int WIDTH = 16;

   typedef enum logic [1:0] {
      KS_ADD  = 2'b00,
      KS_ACC  = 2'b01,
      KS_LOAD = 2'b10,
      KS_CLR  = 2'b11
   } ks_op_e;

   typedef struct packed {
      ks_op_e           op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } ks_beat_t;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } ks_res_t;

   // Flags recovered from operand and sum MSBs only, so the adder stays a plain 16-bit sum.
   function automatic ks_res_t ks_add_flags(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                            logic [WIDTH-1:0] s);
      ks_res_t r;
      r.sum  = s;
      r.cout = (a[WIDTH-1] & b[WIDTH-1]) | ((a[WIDTH-1] ^ b[WIDTH-1]) & ~s[WIDTH-1]);
      r.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
      return r;
   endfunction
endpackage

// File: rtl/ks_add_stream_if.sv
// Operand stream, external adder hookup and result stream of ks_add_stream.
// slave = the stage itself; master = producer/consumer/adder side.
interface ks_add_stream_if;
   import ks_add_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic [WIDTH-1:0] add_res;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;

   modport master (
      output in_valid, in_op, in_a, in_b, add_res, out_ready,
      input  in_ready, add_a, add_b, out_valid, out_sum, out_cout, out_ovf
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, add_res, out_ready,
      output in_ready, add_a, add_b, out_valid, out_sum, out_cout, out_ovf
   );
endinterface

// File: rtl/ks_add_stream_fifo.sv
// 2-entry result FIFO; head reads as zero while empty so the bus is quiet.
// Caller guarantees no push at count 2 without a simultaneous pop.
module ks_out_fifo #(
   parameter int W = 18
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);
   logic [1:0][W-1:0] mem;
   logic              wr_ptr;
   logic              rd_ptr;
   logic              pop_ok;

   assign pop_ok = pop && (count != 2'd0);
   assign dout   = (count != 2'd0) ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop_ok)
            rd_ptr <= ~rd_ptr;
         case ({push, pop_ok})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/ks_add_stream.sv
// Valid/ready front-end for the external 16-bit Kogge-Stone adder with running accumulator.
// Optional: KS_ADD_SAT_EN makes ACC saturate to 16'hFFFF on unsigned carry.
module ks_add_stream
   import ks_add_pkg::*;
(
   input logic             clk,
   input logic             rst_n,
   ks_add_stream_if.slave  bus
);
   ks_beat_t         s1_q;
   logic             s1_valid;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             s1_advance;
   logic             in_rdy;
   logic             pop;
   logic [1:0]       fifo_cnt;
   ks_res_t          res_d;
   ks_res_t          head;

   // The buffer has room unless full; a full buffer still drains this cycle if out_ready.
   assign s1_advance = s1_valid && ((fifo_cnt != 2'd2) || bus.out_ready);
   assign in_rdy     = !s1_valid || s1_advance;
   assign pop        = (fifo_cnt != 2'd0) && bus.out_ready;

   always_comb begin
      op_a = '0;
      op_b = '0;
      if (s1_valid) begin
         case (s1_q.op)
            KS_ADD: begin
               op_a = s1_q.a;
               op_b = s1_q.b;
            end
            KS_ACC: begin
               op_a = acc_q;
               op_b = s1_q.b;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      res_d = '0;
      case (s1_q.op)
         KS_ADD: res_d = ks_add_flags(op_a, op_b, bus.add_res);
         KS_ACC: begin
            res_d = ks_add_flags(op_a, op_b, bus.add_res);
`ifdef KS_ADD_SAT_EN
            if (res_d.cout)
               res_d.sum = '1;
`endif
         end
         KS_LOAD: res_d.sum = s1_q.a;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (in_rdy) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid)
            s1_q <= '{op: ks_op_e'(bus.in_op), a: bus.in_a, b: bus.in_b};
      end
   end

   // The next ACC only reaches S1 after this edge, so acc_q never needs a bypass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (s1_advance) begin
         case (s1_q.op)
            KS_ACC, KS_LOAD: acc_q <= res_d.sum;
            KS_CLR:          acc_q <= '0;
            default:         acc_q <= acc_q;
         endcase
      end
   end

   ks_out_fifo #(.W($bits(ks_res_t))) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (s1_advance),
      .din   (res_d),
      .pop   (pop),
      .dout  (head),
      .count (fifo_cnt)
   );

   assign bus.in_ready  = in_rdy;
   assign bus.add_a     = op_a;
   assign bus.add_b     = op_b;
   assign bus.out_valid = (fifo_cnt != 2'd0);
   assign bus.out_sum   = head.sum;
   assign bus.out_cout  = head.cout;
   assign bus.out_ovf   = head.ovf;
endmodule

// File: tb/tb_ks_add_stream.sv
// Scoreboard bench for ks_add_stream: driver pushes model results, monitor pops on transfer.
module tb_ks_add_stream;
   import ks_add_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] acc_m = 16'd0;
   logic [17:0] exp_q[$];
   logic [17:0] obs[$];

   ks_add_stream_if bus ();
   ks_add_stream dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   assign bus.add_res = bus.add_a + bus.add_b;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endfunction

   // Reference: integer arithmetic on the architectural accumulator, in acceptance order.
   function automatic void model_push(logic [1:0] op, logic [15:0] a, logic [15:0] b);
      logic [16:0] s;
      logic [15:0] x, sum;
      int          ss;
      logic        cout, ovf;
      sum = 16'd0; cout = 1'b0; ovf = 1'b0;
      if (op == 2'd0 || op == 2'd1) begin
         x    = (op == 2'd0) ? a : acc_m;
         s    = {1'b0, x} + {1'b0, b};
         ss   = $signed(x) + $signed(b);
         sum  = s[15:0];
         cout = s[16];
         ovf  = (ss > 32767) || (ss < -32768);
`ifdef KS_ADD_SAT_EN
         if (op == 2'd1 && cout) sum = 16'hFFFF;
`endif
         if (op == 2'd1) acc_m = sum;
      end else if (op == 2'd2) begin
         sum   = a;
         acc_m = a;
      end else begin
         acc_m = 16'd0;
      end
      exp_q.push_back({sum, cout, ovf});
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected got=%h exp=none", {bus.out_sum, bus.out_cout, bus.out_ovf});
         end else begin
            logic [17:0] e;
            e = exp_q.pop_front();
            chk("sb_result", {14'd0, bus.out_sum, bus.out_cout, bus.out_ovf}, {14'd0, e});
         end
         obs.push_back({bus.out_sum, bus.out_cout, bus.out_ovf});
      end
   end

   // Offer one beat for up to max_cyc cycles; called at posedge+1.
   task automatic offer(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int max_cyc, input bit rnd_rdy, output bit ok);
      ok = 1'b0;
      bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
      for (int t = 0; t < max_cyc; t++) begin
         if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (bus.in_ready) begin
            model_push(op, a, b);
            ok = 1'b1;
         end
         @(posedge clk); #1;
         if (ok) break;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input bit rnd_rdy);
      bit ok;
      offer(op, a, b, 200, rnd_rdy, ok);
      if (!ok) begin
         checks++; errors++;
         $display("FAIL send_timeout got=stalled exp=accepted");
      end
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
      #1;
      chk("drain_empty", exp_q.size(), 0);
      @(negedge clk);
      chk("drain_no_dup", bus.out_valid, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int          base, acc_cnt;
      bit          ok;
      logic [17:0] dir_exp[8];
      bus.in_valid = 0; bus.in_op = 0; bus.in_a = 0; bus.in_b = 0; bus.out_ready = 1;
      #2;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_sum", bus.out_sum, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_add_a", bus.add_a, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Latency: accepted at edge N, out_valid seen only after edge N+1.
      base = obs.size();
      bus.in_valid = 1; bus.in_op = 2'd0; bus.in_a = 16'h1234; bus.in_b = 16'h4321;
      @(negedge clk);
      chk("lat_accept", bus.in_ready, 1);
      model_push(2'd0, 16'h1234, 16'h4321);
      @(posedge clk); #1; bus.in_valid = 0;
      @(negedge clk);
      chk("lat_n", bus.out_valid, 0);
      @(negedge clk);
      chk("lat_n1", bus.out_valid, 1);
      @(posedge clk); #1;

      send(2'd0, 16'hFFFF, 16'h0001, 0);
      send(2'd0, 16'h7FFF, 16'h0001, 0);
      send(2'd2, 16'hFFF0, 16'h0000, 0);
      send(2'd1, 16'h0000, 16'h0008, 0);
      send(2'd1, 16'h0000, 16'h0010, 0);
      send(2'd3, 16'h0000, 16'h0000, 0);
      send(2'd1, 16'h0000, 16'h0003, 0);
      drain();
      dir_exp[0] = {16'h5555, 2'b00};
      dir_exp[1] = {16'h0000, 2'b10};
      dir_exp[2] = {16'h8000, 2'b01};
      dir_exp[3] = {16'hFFF0, 2'b00};
      dir_exp[4] = {16'hFFF8, 2'b00};
`ifdef KS_ADD_SAT_EN
      dir_exp[5] = {16'hFFFF, 2'b10};
`else
      dir_exp[5] = {16'h0008, 2'b10};
`endif
      dir_exp[6] = {16'h0000, 2'b00};
      dir_exp[7] = {16'h0003, 2'b00};
      chk("dir_count", obs.size() - base, 8);
      for (int i = 0; i < 8 && base + i < obs.size(); i++)
         chk($sformatf("dir_%0d", i), {14'd0, obs[base+i]}, {14'd0, dir_exp[i]});

      // Backpressure: 5 offered, 3 absorbed.
      bus.out_ready = 0;
      acc_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         offer(2'd0, 16'(i * 16'h1111), 16'h0101, 4, 0, ok);
         if (ok) acc_cnt++;
      end
      chk("bp_accepted", acc_cnt, 3);
      @(negedge clk);
      chk("bp_in_ready_low", bus.in_ready, 0);
      @(posedge clk); #1;
      bus.out_ready = 1;
      @(negedge clk);
      chk("bp_in_ready_back", bus.in_ready, 1);
      @(posedge clk); #1;
      send(2'd0, 16'h3333, 16'h0101, 0);
      send(2'd0, 16'h4444, 16'h0101, 0);
      drain();

      // Asynchronous reset with 2 buffered results and 1 beat in S1.
      bus.out_ready = 0;
      send(2'd2, 16'hABCD, 16'h0, 0);
      send(2'd1, 16'h0, 16'h1111, 0);
      send(2'd1, 16'h0, 16'h2222, 0);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      acc_m = 16'd0;
      chk("ar_out_valid", bus.out_valid, 0);
      chk("ar_outs", {bus.out_sum, bus.out_cout, bus.out_ovf}, 0);
      chk("ar_add_ab", {bus.add_a, bus.add_b}, 0);
      chk("ar_in_ready", bus.in_ready, 1);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1;
      base = obs.size();
      send(2'd1, 16'h0, 16'h0005, 0);
      drain();
      chk("ar_acc_count", obs.size() - base, 1);
      if (obs.size() > base) chk("ar_acc5", {14'd0, obs[base]}, {14'd0, 16'h0005, 2'b00});

      // Randomized traffic with random consumer stalls.
      for (int i = 0; i < 300; i++) begin
         send(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 1);
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
         end
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
